// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: buffers one fetched instruction pair and issues it as one
// group, or splits it across two groups when the younger reads the older's rd.
//
// state  | meaning
// EMPTY  | nothing buffered
// PAIR   | i0 and i1 both pending
// SINGLE | i0 issued after a split, i1 pending
module dual_issue_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_i0,
    input  logic [31:0] in_i1,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] slot0_instr,
    output logic [31:0] slot0_pc,
    output logic        slot1_valid,
    output logic [31:0] slot1_instr,
    output logic [31:0] slot1_pc,
    output logic [15:0] split_count
);

    localparam logic [1:0] EMPTY  = 2'd0;
    localparam logic [1:0] PAIR   = 2'd1;
    localparam logic [1:0] SINGLE = 2'd2;

    logic [1:0]  state;
    logic [31:0] buf_i0;
    logic [31:0] buf_i1;
    logic [31:0] buf_pc;
    logic [31:0] pc_next;
    logic        hazard;
    logic        occupied;
    logic        accept;
    logic        retire;

    function automatic logic writes_rd(input logic [31:0] ins);
        logic w;
        w = 1'b0;
        case (ins[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: w = (ins[11:7] != 5'd0);
            default: w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic reads_rs1(input logic [31:0] ins);
        logic r;
        r = 1'b0;
        case (ins[6:0])
            7'b0110011, 7'b0010011, 7'b0000011,
            7'b0100011, 7'b1100011, 7'b1100111: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic reads_rs2(input logic [31:0] ins);
        logic r;
        r = 1'b0;
        case (ins[6:0])
            7'b0110011, 7'b0100011, 7'b1100011: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Hazard looks only at the buffered pair, never at the fetch inputs.
    always_comb begin
        hazard = writes_rd(buf_i0) &&
                 ((reads_rs1(buf_i1) && (buf_i1[19:15] == buf_i0[11:7])) ||
                  (reads_rs2(buf_i1) && (buf_i1[24:20] == buf_i0[11:7])));
    end

    assign pc_next  = buf_pc + 32'd4;
    assign occupied = (state != EMPTY);
    assign out_valid = occupied;

    assign in_ready = rst && !flush &&
                      ((state == EMPTY) ||
                       (out_ready && ((state == SINGLE) || ((state == PAIR) && !hazard))));

    assign accept = in_valid && in_ready;
    assign retire = out_valid && out_ready;

    // Slot data reads as zero while nothing is buffered.
    always_comb begin
        slot0_instr = 32'd0;
        slot0_pc    = 32'd0;
        slot1_valid = 1'b0;
        slot1_instr = 32'd0;
        slot1_pc    = 32'd0;
        if (state == PAIR) begin
            slot0_instr = buf_i0;
            slot0_pc    = buf_pc;
            slot1_valid = !hazard;
            slot1_instr = buf_i1;
            slot1_pc    = pc_next;
        end else if (state == SINGLE) begin
            slot0_instr = buf_i1;
            slot0_pc    = pc_next;
            slot1_instr = buf_i1;
            slot1_pc    = pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= EMPTY;
            buf_i0      <= 32'd0;
            buf_i1      <= 32'd0;
            buf_pc      <= 32'd0;
            split_count <= 16'd0;
        end else if (flush) begin
            state <= EMPTY;
        end else if (accept) begin
            state  <= PAIR;
            buf_i0 <= in_i0;
            buf_i1 <= in_i1;
            buf_pc <= in_pc;
        end else if (retire) begin
            if ((state == PAIR) && hazard) begin
                state <= SINGLE;
                if (split_count != 16'hFFFF) begin
                    split_count <= split_count + 16'd1;
                end
            end else begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler: a negedge monitor scoreboards every retired
// issue group against a reference hazard model; the main sequence checks timing/state.
module tb_dual_issue_scheduler;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_i0;
    logic [31:0] in_i1;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] slot0_instr;
    logic [31:0] slot0_pc;
    logic        slot1_valid;
    logic [31:0] slot1_instr;
    logic [31:0] slot1_pc;
    logic [15:0] split_count;

    typedef struct packed {
        logic [31:0] s0_instr;
        logic [31:0] s0_pc;
        logic        s1_valid;
        logic [31:0] s1_instr;
        logic [31:0] s1_pc;
    } group_t;

    group_t sb[$];
    group_t mon_e;
    int     checks = 0;
    int     errors = 0;

    dual_issue_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_i0       (in_i0),
        .in_i1       (in_i1),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .slot0_instr (slot0_instr),
        .slot0_pc    (slot0_pc),
        .slot1_valid (slot1_valid),
        .slot1_instr (slot1_instr),
        .slot1_pc    (slot1_pc),
        .split_count (split_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model of the RAW check, written from the opcode tables.
    function automatic logic model_hazard(input logic [31:0] a, input logic [31:0] b);
        logic [6:0] oa;
        logic [6:0] ob;
        logic       wr;
        logic       r1;
        logic       r2;
        oa = a[6:0];
        ob = b[6:0];
        wr = (oa inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67}) && (a[11:7] != 5'd0);
        r1 = (ob inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67}) && (b[19:15] == a[11:7]);
        r2 = (ob inside {7'h33, 7'h23, 7'h63}) && (b[24:20] == a[11:7]);
        return wr && (r1 || r2);
    endfunction

    task automatic push_pair(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
        group_t g;
        if (model_hazard(i0, i1)) begin
            g = '{s0_instr: i0, s0_pc: pc, s1_valid: 1'b0, s1_instr: i1, s1_pc: pc + 32'd4};
            sb.push_back(g);
            g = '{s0_instr: i1, s0_pc: pc + 32'd4, s1_valid: 1'b0, s1_instr: 32'd0, s1_pc: 32'd0};
            sb.push_back(g);
        end else begin
            g = '{s0_instr: i0, s0_pc: pc, s1_valid: 1'b1, s1_instr: i1, s1_pc: pc + 32'd4};
            sb.push_back(g);
        end
    endtask

    // Scoreboard monitor: flush or reset kills everything still pending.
    always @(negedge clk) begin
        if (!rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_group", {31'd0, out_valid}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_slot0_instr", slot0_instr, mon_e.s0_instr);
                    chk("sb_slot0_pc", slot0_pc, mon_e.s0_pc);
                    chk("sb_slot1_valid", {31'd0, slot1_valid}, {31'd0, mon_e.s1_valid});
                    if (mon_e.s1_valid) begin
                        chk("sb_slot1_instr", slot1_instr, mon_e.s1_instr);
                        chk("sb_slot1_pc", slot1_pc, mon_e.s1_pc);
                    end
                end
            end
            if (in_valid && in_ready) begin
                push_pair(in_i0, in_i1, in_pc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
        in_valid = 1'b1;
        in_i0    = i0;
        in_i1    = i1;
        in_pc    = pc;
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_i0     = 32'd0;
        in_i1     = 32'd0;
        in_pc     = 32'd0;
        out_ready = 1'b1;

        // reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_slot1_valid", {31'd0, slot1_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_split", {16'd0, split_count}, 32'd0);
        chk("rst_slot0_pc", slot0_pc, 32'd0);
        chk("rst_slot1_pc", slot1_pc, 32'd0);
        rst = 1'b1;

        // independent pair dual-issues one cycle after accept
        tick();
        drive(32'h00500093, 32'h00318133, 32'h100);
        @(negedge clk);
        chk("a_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("a_out_valid", {31'd0, out_valid}, 32'd1);
        chk("a_slot1_valid", {31'd0, slot1_valid}, 32'd1);
        chk("a_slot1_pc", slot1_pc, 32'h104);
        chk("a_split", {16'd0, split_count}, 32'd0);
        tick();
        @(negedge clk);
        chk("a_empty", {31'd0, out_valid}, 32'd0);

        // RAW hazard via rs1 splits the pair
        tick();
        drive(32'h00500093, 32'h00108133, 32'h200);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("b_c1_slot1_valid", {31'd0, slot1_valid}, 32'd0);
        chk("b_c1_in_ready", {31'd0, in_ready}, 32'd0);
        chk("b_c1_slot0_pc", slot0_pc, 32'h200);
        tick();
        @(negedge clk);
        chk("b_c2_in_ready", {31'd0, in_ready}, 32'd1);
        chk("b_c2_slot0_instr", slot0_instr, 32'h00108133);
        chk("b_c2_slot0_pc", slot0_pc, 32'h204);
        chk("b_c2_split", {16'd0, split_count}, 32'd1);
        tick();
        @(negedge clk);
        chk("b_empty", {31'd0, out_valid}, 32'd0);

        // rd = x0 never creates a hazard
        tick();
        drive(32'h00500013, 32'h00000133, 32'h300);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("c_x0_slot1_valid", {31'd0, slot1_valid}, 32'd1);
        // store reading i0.rd through rs2 splits
        tick();
        drive(32'h00500093, 32'h00112023, 32'h340);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("c_st_slot1_valid", {31'd0, slot1_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("c_st_split", {16'd0, split_count}, 32'd2);
        chk("c_st_slot0_instr", slot0_instr, 32'h00112023);
        tick();

        // backpressure on a hazard pair holds everything
        out_ready = 1'b0;
        drive(32'h00500093, 32'h00108133, 32'h400);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("d_hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("d_hold_slot0_instr", slot0_instr, 32'h00500093);
            chk("d_hold_slot0_pc", slot0_pc, 32'h400);
            chk("d_hold_slot1_valid", {31'd0, slot1_valid}, 32'd0);
            chk("d_hold_split", {16'd0, split_count}, 32'd2);
            chk("d_hold_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("d_split_after", {16'd0, split_count}, 32'd3);
        chk("d_single_pc", slot0_pc, 32'h404);
        tick();

        // flush while SINGLE drops the pending i1
        drive(32'h00500093, 32'h00108133, 32'h500);
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("e_flush_out_valid", {31'd0, out_valid}, 32'd1);
        chk("e_flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("e_post_out_valid", {31'd0, out_valid}, 32'd0);
        chk("e_post_split", {16'd0, split_count}, 32'd4);
        tick();
        @(negedge clk);
        chk("e_still_empty", {31'd0, out_valid}, 32'd0);

        // reset while SINGLE clears everything
        tick();
        drive(32'h00500093, 32'h00108133, 32'h600);
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("f_rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("f_out_valid", {31'd0, out_valid}, 32'd0);
        chk("f_split", {16'd0, split_count}, 32'd0);
        chk("f_slot0_instr", slot0_instr, 32'd0);
        chk("f_slot1_pc", slot1_pc, 32'd0);
        rst = 1'b1;

        // ten back-to-back independent pairs, no bubbles
        for (int k = 0; k <= 10; k++) begin
            tick();
            if (k < 10) begin
                drive({12'(k), 5'd0, 3'b000, 5'd5, 7'b0010011},
                      {7'd0, 5'd8, 5'd7, 3'b000, 5'd6, 7'b0110011},
                      32'h1000 + 32'(8 * k));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (k > 0) begin
                chk("g_out_valid", {31'd0, out_valid}, 32'd1);
                chk("g_slot1_valid", {31'd0, slot1_valid}, 32'd1);
            end
            if (k < 10) begin
                chk("g_in_ready", {31'd0, in_ready}, 32'd1);
            end
        end
        tick();
        @(negedge clk);
        chk("g_empty", {31'd0, out_valid}, 32'd0);

        // PC wraps modulo 2^32
        tick();
        drive(32'h00500093, 32'h00318133, 32'hFFFF_FFFC);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("h_wrap_slot1_pc", slot1_pc, 32'h0);
        tick();
        drive(32'h00500093, 32'h00108133, 32'hFFFF_FFFC);
        tick();
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("h_wrap_single_pc", slot0_pc, 32'h0);
        tick();
        tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
